rect_fill_engine: RTL and testbench

RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

---
 rtl/rect_fill_engine.sv | 160 ++++++++++++++++
 tb/tb_rect_fill_engine.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: fills a w x h rectangle one pixel per clock in raster order.
// Optional build macro RECT_FILL_ENGINE_CLIP_EN: pixels outside the SCR_W x SCR_H
// screen are still stepped through but emitted with plot low.
//
// state  | meaning
// S_IDLE | waiting for start, operands not yet latched
// S_DRAW | px/py/pc show pixel (ix,iy) of the latched rectangle
// S_FIN  | done pulse, back to S_IDLE next cycle
module rect_fill_engine #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int C_W   = 3,
    parameter int DIM_W = 4,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic             clk,
    input  logic             r_set,
    input  logic             start,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [DIM_W-1:0] w,
    input  logic [DIM_W-1:0] h,
    input  logic [C_W-1:0]   colour,
    output logic             busy,
    output logic             done,
    output logic             plot,
    output logic [X_W-1:0]   px,
    output logic [Y_W-1:0]   py,
    output logic [C_W-1:0]   pc
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FIN} state_t;

    state_t           state_q;
    logic [X_W-1:0]   x_l_q;
    logic [Y_W-1:0]   y_l_q;
    logic [DIM_W-1:0] w_l_q, h_l_q;
    logic [C_W-1:0]   c_l_q;
    logic [DIM_W-1:0] ix_q, iy_q;
    logic             busy_q, done_q, plot_q;
    logic [X_W-1:0]   px_q;
    logic [Y_W-1:0]   py_q;
    logic [C_W-1:0]   pc_q;

    logic [DIM_W-1:0] ix_d, iy_d;
    logic [X_W:0]     sx_d;
    logic [Y_W:0]     sy_d;
    logic [C_W-1:0]   col_d;
    logic             row_end, last_px, in_scr, vis_d;

    // Index and address of the pixel to show next cycle; in IDLE that is the
    // first pixel of the request on the input pins.
    always_comb begin
        row_end = (ix_q == w_l_q - DIM_W'(1));
        last_px = row_end && (iy_q == h_l_q - DIM_W'(1));
        if (state_q == S_IDLE) begin
            ix_d  = '0;
            iy_d  = '0;
            sx_d  = {1'b0, x0};
            sy_d  = {1'b0, y0};
            col_d = colour;
        end else begin
            ix_d  = row_end ? '0 : ix_q + DIM_W'(1);
            iy_d  = row_end ? iy_q + DIM_W'(1) : iy_q;
            sx_d  = {1'b0, x_l_q} + (X_W+1)'(ix_d);
            sy_d  = {1'b0, y_l_q} + (Y_W+1)'(iy_d);
            col_d = c_l_q;
        end
        in_scr = (sx_d < (X_W+1)'(SCR_W)) && (sy_d < (Y_W+1)'(SCR_H));
`ifdef RECT_FILL_ENGINE_CLIP_EN
        vis_d = in_scr;
`else
        // Without clipping the screen extent has no effect; sums wrap.
        vis_d = in_scr | 1'b1;
`endif
    end

    // Control FSM with registered strobes and pixel outputs.
    always_ff @(posedge clk) begin
        if (r_set) begin
            state_q <= S_IDLE;
            x_l_q   <= '0;
            y_l_q   <= '0;
            w_l_q   <= '0;
            h_l_q   <= '0;
            c_l_q   <= '0;
            ix_q    <= '0;
            iy_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            plot_q  <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            pc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_l_q  <= x0;
                        y_l_q  <= y0;
                        w_l_q  <= w;
                        h_l_q  <= h;
                        c_l_q  <= colour;
                        ix_q   <= '0;
                        iy_q   <= '0;
                        busy_q <= 1'b1;
                        if (w != '0 && h != '0) begin
                            state_q <= S_DRAW;
                            plot_q  <= vis_d;
                            if (vis_d) begin
                                px_q <= sx_d[X_W-1:0];
                                py_q <= sy_d[Y_W-1:0];
                                pc_q <= col_d;
                            end
                        end else begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DRAW: begin
                    if (last_px) begin
                        state_q <= S_FIN;
                        plot_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        ix_q   <= ix_d;
                        iy_q   <= iy_d;
                        plot_q <= vis_d;
                        if (vis_d) begin
                            px_q <= sx_d[X_W-1:0];
                            py_q <= sy_d[Y_W-1:0];
                            pc_q <= col_d;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    plot_q  <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign plot = plot_q;
    assign px   = px_q;
    assign py   = py_q;
    assign pc   = pc_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine (default 8/7/3/4 geometry, 160x120 screen).
module tb_rect_fill_engine;

`ifdef RECT_FILL_ENGINE_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       r_set, start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [3:0] w, h;
    logic [2:0] colour;
    logic       busy, done, plot;
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int busy_n = 0;
    int plot_x[$], plot_y[$], plot_c[$], plot_t[$], done_t[$];

    rect_fill_engine dut (
        .clk(clk), .r_set(r_set), .start(start),
        .x0(x0), .y0(y0), .w(w), .h(h), .colour(colour),
        .busy(busy), .done(done), .plot(plot),
        .px(px), .py(py), .pc(pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle.
    always @(negedge clk) begin
        if (plot) begin
            plot_x.push_back(int'(px));
            plot_y.push_back(int'(py));
            plot_c.push_back(int'(pc));
            plot_t.push_back(cyc);
        end
        if (done) done_t.push_back(cyc);
        if (busy) busy_n = busy_n + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        plot_x.delete(); plot_y.delete(); plot_c.delete();
        plot_t.delete(); done_t.delete();
        busy_n = 0;
    endtask

    // Drives one start cycle; returns on the negedge of the first output cycle.
    task automatic apply_start(input int x, input int y, input int ww, input int hh,
                               input int c, output int n);
        @(negedge clk);
        x0 = 8'(x); y0 = 7'(y); w = 4'(ww); h = 4'(hh); colour = 3'(c);
        start = 1'b1;
        n = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_rect(input string tag, input int x, input int y, input int ww,
                            input int hh, input int c, input bit disturb);
        int n, k, sx, sy, ne;
        int ex[$], ey[$], et[$];
        clr();
        apply_start(x, y, ww, hh, c, n);
        if (disturb) begin
            @(negedge clk); start = 1'b1; x0 = 8'd99; y0 = 7'd99; w = 4'd1; colour = 3'd0;
            @(negedge clk);
            @(negedge clk); start = 1'b0;
            repeat (ww*hh - 1) @(negedge clk);
        end else begin
            repeat (ww*hh + 2) @(negedge clk);
        end
        k = 0;
        for (int j = 0; j < hh; j++)
            for (int i = 0; i < ww; i++) begin
                sx = x + i; sy = y + j;
                if (!(CLIP && (sx >= 160 || sy >= 120))) begin
                    ex.push_back(sx % 256); ey.push_back(sy % 128); et.push_back(n + 1 + k);
                end
                k++;
            end
        chk({tag, "_nplot"}, plot_x.size(), ex.size());
        ne = (plot_x.size() < ex.size()) ? plot_x.size() : ex.size();
        for (int i = 0; i < ne; i++) begin
            chk({tag, "_px"}, plot_x[i], ex[i]);
            chk({tag, "_py"}, plot_y[i], ey[i]);
            chk({tag, "_pc"}, plot_c[i], c);
            chk({tag, "_pt"}, plot_t[i], et[i]);
        end
        chk({tag, "_ndone"}, done_t.size(), 1);
        if (done_t.size() > 0) chk({tag, "_done_t"}, done_t[0], n + ww*hh + 1);
        chk({tag, "_busy_cyc"}, busy_n, ww*hh + 1);
    endtask

    initial begin
        int n, m;
        r_set = 1'b1; start = 1'b0; x0 = '0; y0 = '0; w = '0; h = '0; colour = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_plot", plot, 0);
        chk("rst_px", px, 0);
        chk("rst_py", py, 0);
        chk("rst_pc", pc, 0);
        r_set = 1'b0;
        @(negedge clk);

        run_rect("r4x4", 10, 20, 4, 4, 5, 1'b0);
        run_rect("zero_w", 40, 50, 0, 3, 6, 1'b0);
        run_rect("zero_h", 40, 50, 3, 0, 6, 1'b0);
        run_rect("ign_start", 30, 40, 3, 2, 2, 1'b1);
        run_rect("edge", 158, 118, 4, 4, 7, 1'b0);
        run_rect("wrap", 254, 126, 4, 4, 1, 1'b0);
        run_rect("max", 0, 0, 15, 15, 4, 1'b0);

        // Reset on the fifth pixel, then r_set held against a start request.
        clr();
        apply_start(10, 20, 4, 4, 5, n);
        repeat (4) @(negedge clk);
        chk("abort_plot5", plot, 1);
        chk("abort_py5", py, 21);
        r_set = 1'b1; start = 1'b1; x0 = 8'd77;
        @(negedge clk);
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_px", px, 0);
        @(negedge clk);
        chk("prio_busy", busy, 0);
        chk("prio_plot", plot, 0);
        r_set = 1'b0; x0 = 8'd1; y0 = 7'd2; w = 4'd1; h = 4'd1; colour = 3'd3;
        m = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("restart_plot", plot, 1);
        chk("restart_px", px, 1);
        chk("restart_py", py, 2);
        chk("restart_pc", pc, 3);
        @(negedge clk);
        chk("restart_done", done, 1);
        repeat (2) @(negedge clk);
        chk("abort_nplot", plot_x.size(), 6);
        chk("abort_ndone", done_t.size(), 1);
        if (done_t.size() > 0) chk("restart_done_t", done_t[0], m + 2);

        // Back-to-back: second start in the first IDLE cycle after done.
        clr();
        apply_start(5, 6, 2, 2, 1, n);
        repeat (4) @(negedge clk);
        chk("b2b_done1", done, 1);
        apply_start(50, 60, 1, 1, 4, m);
        chk("b2b_accept", m, n + 6);
        repeat (3) @(negedge clk);
        chk("b2b_ndone", done_t.size(), 2);
        if (done_t.size() > 1) begin
            chk("b2b_done_t0", done_t[0], n + 5);
            chk("b2b_done_t1", done_t[1], n + 8);
        end
        chk("b2b_nplot", plot_x.size(), 5);
        if (plot_x.size() > 4) begin
            chk("b2b_px4", plot_x[4], 50);
            chk("b2b_pt4", plot_t[4], n + 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
